serial_port_demux: RTL and testbench

Serial-to-port router with a 7-segment count display. An idle-high serial line carries a frame: start bit 0, a 2-bit port address, a 4-bit payload length, then the payload bits. The block steers each payload bit onto one of four output ports and flags valid data and frame completion. It shows the remaining payload length on a hex 7-segment digit. It is the top level of the transmitter lab design; all state advances only on clock-enabled cycles.

---
 rtl/serial_port_demux_pkg.sv | 21 ++
 rtl/serial_port_demux_hex_to_ssd.sv | 11 +
 rtl/serial_port_demux.sv | 92 +++++++++
 tb/tb_serial_port_demux.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/serial_port_demux_pkg.sv
// Shared types and constants for the serial port demultiplexer:
// FSM state encoding and the active-low hex 7-segment table.
package serial_port_demux_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PORT  = 3'd1,
    COUNT = 3'd2,
    DATA  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, a 0 lights the segment.
  localparam logic [6:0] SSD_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/serial_port_demux_hex_to_ssd.sv
// Hex nibble to active-low 7-segment decoder.
module hex_to_ssd
  import serial_port_demux_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SSD_LUT[hex];

endmodule

// File: rtl/serial_port_demux.sv
// Serial frame router: start bit, 2-bit port, 4-bit length, payload steered
// to one of four ports; remaining length shown on a hex 7-segment digit.
module serial_port_demux
  import serial_port_demux_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clkEn,
  input  logic       SerIn,
  output logic       SerOutValid,
  output logic       Done,
  output logic       P0,
  output logic       P1,
  output logic       P2,
  output logic       P3,
  output logic [6:0] SSD_Out
);

  state_t     state, state_nx;
  logic [1:0] port, port_nx;
  logic [3:0] cnt, cnt_nx;
  logic [1:0] bit_cnt, bit_cnt_nx;
  logic [3:0] p_vec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      port    <= '0;
      cnt     <= '0;
      bit_cnt <= '0;
    end else if (clkEn) begin
      state   <= state_nx;
      port    <= port_nx;
      cnt     <= cnt_nx;
      bit_cnt <= bit_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    port_nx    = port;
    cnt_nx     = cnt;
    bit_cnt_nx = bit_cnt;
    case (state)
      IDLE: begin
        if (!SerIn) begin
          state_nx   = PORT;
          bit_cnt_nx = '0;
        end
      end
      PORT: begin
        port_nx    = {port[0], SerIn};
        bit_cnt_nx = bit_cnt + 2'd1;
        if (bit_cnt == 2'd1) begin
          state_nx   = COUNT;
          bit_cnt_nx = '0;
        end
      end
      COUNT: begin
        cnt_nx     = {cnt[2:0], SerIn};
        bit_cnt_nx = bit_cnt + 2'd1;
        if (bit_cnt == 2'd3) begin
          bit_cnt_nx = '0;
          // A zero-length frame skips DATA entirely.
          state_nx   = (cnt_nx == 4'd0) ? DONE : DATA;
        end
      end
      DATA: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign SerOutValid = (state == DATA);
  assign Done        = (state == DONE);

  // Selected port follows SerIn combinationally during payload.
  assign p_vec = (state == DATA) ? (4'(SerIn) << port) : 4'b0000;
  assign P0 = p_vec[0];
  assign P1 = p_vec[1];
  assign P2 = p_vec[2];
  assign P3 = p_vec[3];

  hex_to_ssd u_ssd (
    .hex (cnt),
    .seg (SSD_Out)
  );

endmodule

// File: tb/tb_serial_port_demux.sv
// Directed self-checking bench for serial_port_demux.
module tb_serial_port_demux;

  logic       clk = 1'b0;
  logic       rst;
  logic       clkEn;
  logic       SerIn;
  logic       SerOutValid, Done, P0, P1, P2, P3;
  logic [6:0] SSD_Out;

  int pass_cnt = 0;
  int total    = 0;

  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  serial_port_demux dut (
    .clk         (clk),
    .rst         (rst),
    .clkEn       (clkEn),
    .SerIn       (SerIn),
    .SerOutValid (SerOutValid),
    .Done        (Done),
    .P0          (P0),
    .P1          (P1),
    .P2          (P2),
    .P3          (P3),
    .SSD_Out     (SSD_Out)
  );

  always #5 clk = ~clk;

  // Observed vector: {P3,P2,P1,P0,SerOutValid,Done,SSD_Out}
  function automatic logic [12:0] obs();
    return {P3, P2, P1, P0, SerOutValid, Done, SSD_Out};
  endfunction

  task automatic check(input string tag, input logic [12:0] exp);
    logic [12:0] got;
    got = obs();
    total++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s: observed %b expected %b", tag, got, exp);
  endtask

  task automatic drive(input logic b);
    SerIn = b;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hdr(input logic [1:0] p, input logic [3:0] n);
    drive(1'b0); tick();
    for (int i = 1; i >= 0; i--) begin drive(p[i]); tick(); end
    for (int i = 3; i >= 0; i--) begin drive(n[i]); tick(); end
  endtask

  logic [12:0] idle_v, done_v;
  logic        b;

  initial begin
    idle_v = {4'b0000, 1'b0, 1'b0, SEG[0]};
    done_v = {4'b0000, 1'b0, 1'b1, SEG[0]};
    rst = 1'b0; clkEn = 1'b1; SerIn = 1'b1;
    #12;
    check("reset", idle_v);
    @(negedge clk); rst = 1'b1;
    #1;
    repeat (10) tick();
    check("idle_hold", idle_v);

    // Frame 1: port 2, length 10, alternating payload
    drive(1'b0); tick();
    drive(1'b1); tick();
    drive(1'b0); tick();
    drive(1'b1); tick(); check("f1_cnt1", {6'b0, SEG[1]});
    drive(1'b0); tick(); check("f1_cnt2", {6'b0, SEG[2]});
    drive(1'b1); tick(); check("f1_cnt5", {6'b0, SEG[5]});
    drive(1'b0); tick();
    for (int i = 0; i < 10; i++) begin
      b = i[0];
      drive(b);
      check("f1_data", {1'b0, b, 2'b00, 1'b1, 1'b0, SEG[10-i]});
      tick();
    end
    drive(1'b0);
    check("f1_done", done_v);
    tick();
    drive(1'b1);
    check("f1_idle", idle_v);
    tick();

    // Frame 2: port 0, length 1
    hdr(2'd0, 4'd1);
    drive(1'b1);
    check("f2_data", {4'b0001, 1'b1, 1'b0, SEG[1]});
    tick();
    check("f2_done", done_v);
    tick();
    check("f2_idle", idle_v);

    // Frame 3: zero length goes straight to DONE
    hdr(2'd1, 4'd0);
    drive(1'b1);
    check("f3_done", done_v);
    tick();
    check("f3_idle", idle_v);

    // Frame 4: clkEn gap mid-payload
    hdr(2'd1, 4'd3);
    drive(1'b1);
    check("f4_data0", {4'b0010, 1'b1, 1'b0, SEG[3]});
    tick();
    clkEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b = i[0];
      drive(b);
      check("f4_frozen", {2'b00, b, 1'b0, 1'b1, 1'b0, SEG[2]});
      tick();
    end
    clkEn = 1'b1;
    drive(1'b0);
    check("f4_data1", {4'b0000, 1'b1, 1'b0, SEG[2]});
    tick();
    drive(1'b1);
    check("f4_data2", {4'b0010, 1'b1, 1'b0, SEG[1]});
    tick();
    check("f4_done", done_v);
    tick();
    check("f4_idle", idle_v);

    // Frame 5: reset in the middle of DATA
    hdr(2'd0, 4'd5);
    drive(1'b1); tick();
    drive(1'b1); tick();
    rst = 1'b0;
    #1;
    check("f5_reset", idle_v);
    SerIn = 1'b1;
    @(negedge clk); rst = 1'b1;
    #1;

    // Frame 6: port 3, length 2
    hdr(2'd3, 4'd2);
    drive(1'b1);
    check("f6_data0", {4'b1000, 1'b1, 1'b0, SEG[2]});
    tick();
    drive(1'b1);
    check("f6_data1", {4'b1000, 1'b1, 1'b0, SEG[1]});
    tick();
    check("f6_done", done_v);
    tick();
    check("f6_idle", idle_v);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
